// File: rtl/hex_seq_pkg.sv
// Shared types and constants for the hex display sequencer.
package hex_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_VALUE   = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/hex_seg_decoder.sv
// Nibble to active-low seven-segment pattern, bit order gfedcba.
module hex_seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Slave-programmed 4-digit hex value pushed to digit PIOs through a simple master port.
// Optional macro HEX_BLANK_LEADING_ZEROS_EN blanks leading zero digits 3..1.
module hex_display_sequencer
  import hex_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t           state_reg, state_next;
  logic [15:0]      value_reg, snap_reg;
  logic             enable_reg, snap_en_reg, pending_reg;
  logic [IDX_W-1:0] idx_reg;

  logic slave_wr, start, digit_done, last_digit;
  logic [6:0] seg_arr   [NUM_DIGITS];
  logic [6:0] digit_pat [NUM_DIGITS];

  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata[31:16]};

  assign slave_wr   = chipselect && !write_n;
  assign start      = (state_reg == ST_IDLE) && pending_reg;
  assign digit_done = (state_reg == ST_WRITE) && !m_waitrequest;
  assign last_digit = (idx_reg == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pending_reg) state_next = ST_WRITE;
      ST_WRITE: if (digit_done && last_digit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A write in the snapshot cycle wins over the clear, so pending survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg   <= 16'h0000;
      enable_reg  <= 1'b1;
      pending_reg <= 1'b1;
      snap_reg    <= 16'h0000;
      snap_en_reg <= 1'b1;
      idx_reg     <= '0;
    end else begin
      if (slave_wr && address == ADDR_VALUE)   value_reg  <= writedata[15:0];
      if (slave_wr && address == ADDR_CONTROL) enable_reg <= writedata[0];

      if (slave_wr && (address == ADDR_VALUE || address == ADDR_CONTROL))
        pending_reg <= 1'b1;
      else if (start)
        pending_reg <= 1'b0;

      if (start) begin
        snap_reg    <= value_reg;
        snap_en_reg <= enable_reg;
        idx_reg     <= '0;
      end else if (digit_done) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      hex_seg_decoder u_dec (
        .nibble (snap_reg[4*gi +: 4]),
        .seg    (seg_arr[gi])
      );
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      if (gi == 0) begin : g_keep
        assign digit_pat[gi] = seg_arr[gi];
      end else begin : g_blank
        assign digit_pat[gi] = (snap_reg[15:4*gi] == '0) ? SEG_BLANK : seg_arr[gi];
      end
`else
      assign digit_pat[gi] = seg_arr[gi];
`endif
    end
  endgenerate

  // Outputs depend only on registered state, so they hold steady during a stall.
  always_comb begin
    m_write     = 1'b0;
    m_address   = 2'd0;
    m_writedata = 32'h0;
    if (state_reg == ST_WRITE) begin
      m_write     = 1'b1;
      m_address   = 2'(idx_reg);
      m_writedata = {25'h0, snap_en_reg ? digit_pat[idx_reg] : SEG_BLANK};
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_VALUE:   readdata = {16'h0, value_reg};
      ADDR_STATUS:  readdata = {30'h0, pending_reg, state_reg == ST_WRITE};
      ADDR_CONTROL: readdata = {31'h0, enable_reg};
      ADDR_RSVD:    readdata = 32'h0;
      default:      readdata = 32'h0;
    endcase
  end

endmodule
